// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - multiplexed seven-segment scan driver with tear-free frame updates
module hex_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD           = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Idle (unlit) levels of every output, folded for the configured polarity.
    localparam logic [DIGITS-1:0] AN_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  cnt_last;
    logic                  idx_last;
    logic                  wrap;
    logic                  wrap_q;

    // Shadow copy collects loads during a frame; display copy is what is scanned.
    logic [4*DIGITS-1:0]   sh_value;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;
    logic                  sh_lz;
    logic [4*DIGITS-1:0]   d_value;
    logic [DIGITS-1:0]     d_dp;
    logic [DIGITS-1:0]     d_blank;
    logic                  d_lz;

    logic [DIGITS-1:0]     suppress;
    logic                  zero_run;
    logic [3:0]            nib;
    logic                  in_dead;
    logic                  cur_blank;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [DIGITS-1:0]     an_on;
    logic [6:0]            seg_nx;
    logic                  dp_nx;
    logic [DIGITS-1:0]     an_nx;

    // Hex glyph in active-high a..g order (seg[6]=a ... seg[0]=g).
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
    assign idx_last = (idx == IW'(DIGITS - 1));
    assign wrap     = cnt_last && idx_last;

    // Slot counter and digit index; the index advances once per slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Capture host inputs on every load; later loads in a frame overwrite earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
            sh_lz    <= lz_en;
        end
    end

    // Display only changes on the frame wrap; a load on that same edge bypasses the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_value <= '0;
            d_dp    <= '0;
            d_blank <= '0;
            d_lz    <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                d_value <= value;
                d_dp    <= dp_in;
                d_blank <= blank_in;
                d_lz    <= lz_en;
            end else begin
                d_value <= sh_value;
                d_dp    <= sh_dp;
                d_blank <= sh_blank;
                d_lz    <= sh_lz;
            end
        end
    end

    // Leading-zero mask: digit k is suppressed when it and every higher nibble are zero.
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (d_value[4*k +: 4] == 4'h0);
            suppress[k] = d_lz && (k != 0) && zero_run;
        end
    end

    // Next output levels for the current (cnt, idx), including dead time and blanking.
    always_comb begin
        nib       = d_value[{idx, 2'b00} +: 4];
        in_dead   = (cnt < CW'(DEAD));
        cur_blank = d_blank[idx] || suppress[idx];
        seg_on    = 7'b0;
        dp_on     = 1'b0;
        an_on     = '0;
        if (!in_dead) begin
            for (int k = 0; k < DIGITS; k++) begin
                an_on[k] = (idx == IW'(k));
            end
            dp_on = d_dp[idx];
            if (!cur_blank) begin
                seg_on = glyph(nib);
            end
        end
        seg_nx = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_nx  = (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
        an_nx  = (DIG_ACTIVE_LOW != 0) ? ~an_on  : an_on;
    end

    // Registered outputs lag the counter by one cycle; frame marks the first output cycle of slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= SEG_OFF;
            dp     <= DP_OFF;
            an     <= AN_OFF;
            wrap_q <= 1'b0;
            frame  <= 1'b0;
        end else begin
            seg    <= seg_nx;
            dp     <= dp_nx;
            an     <= an_nx;
            wrap_q <= wrap;
            frame  <= wrap_q;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - directed self-checking bench for hex_scan_driver
module tb_hex_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int vectors;
    int miscompares;
    int n;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b1100000;
    localparam logic [6:0] GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000;
    localparam logic [6:0] GX = 7'b1111111;

    hex_scan_driver #(
        .DIGITS(4),
        .REFRESH_DIV(4),
        .DEAD(1),
        .SEG_ACTIVE_LOW(1),
        .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .lz_en(lz_en),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed, input logic ef);
        chk({tag, ".an"},    32'(an),    32'(ea));
        chk({tag, ".seg"},   32'(seg),   32'(es));
        chk({tag, ".dp"},    32'(dp),    32'(ed));
        chk({tag, ".frame"}, 32'(frame), 32'(ef));
    endtask

    // One slot: a dead cycle, then three lit cycles of digit k; ends on the next slot's first sample.
    task automatic check_slot(input int k, input logic [6:0] es, input logic ed);
        logic [3:0] ea;
        ea = ~(4'b0001 << k);
        chk_out($sformatf("dead%0d", k), 4'b1111, GX, 1'b1, (k == 0));
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out($sformatf("slot%0d_c%0d", k, c), ea, es, ed, 1'b0);
        end
        step();
    endtask

    task automatic load_vec(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                            input logic lz);
        value    = v;
        dp_in    = d;
        blank_in = b;
        lz_en    = lz;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_in = '0;
        lz_en    = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 4'b1111, GX, 1'b1, 1'b0);
        end
        rst = 1'b0;

        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 40);
        chk("first_frame_edges", 32'(n), 32'd17);

        for (int k = 0; k < 4; k++) check_slot(k, G0, 1'b1);

        load_vec(16'h12A5, 4'b0000, 4'b0000, 1'b0);
        repeat (15) step();
        check_slot(0, G5, 1'b1);
        check_slot(1, GA, 1'b1);
        check_slot(2, G2, 1'b1);
        check_slot(3, G1, 1'b1);

        load_vec(16'h0070, 4'b0000, 4'b0000, 1'b1);
        repeat (15) step();
        check_slot(0, G0, 1'b1);
        check_slot(1, G7, 1'b1);
        check_slot(2, GX, 1'b1);
        check_slot(3, GX, 1'b1);

        load_vec(16'h0000, 4'b0000, 4'b0000, 1'b1);
        repeat (15) step();
        check_slot(0, G0, 1'b1);
        check_slot(1, GX, 1'b1);
        check_slot(2, GX, 1'b1);
        check_slot(3, GX, 1'b1);

        check_slot(0, G0, 1'b1);
        chk_out("tear_dead1", 4'b1111, GX, 1'b1, 1'b0);
        load_vec(16'hFFFF, 4'b0000, 4'b0000, 1'b0);
        chk_out("tear_s1", 4'b1101, GX, 1'b1, 1'b0);
        load_vec(16'h1234, 4'b0000, 4'b0000, 1'b0);
        chk_out("tear_s2", 4'b1101, GX, 1'b1, 1'b0);
        step();
        chk_out("tear_s3", 4'b1101, GX, 1'b1, 1'b0);
        step();
        check_slot(2, GX, 1'b1);
        check_slot(3, GX, 1'b1);
        check_slot(0, G4, 1'b1);
        check_slot(1, G3, 1'b1);
        check_slot(2, G2, 1'b1);
        check_slot(3, G1, 1'b1);

        repeat (14) step();
        load_vec(16'hBEEF, 4'b0000, 4'b0000, 1'b0);
        chk_out("bypass_old", 4'b0111, G1, 1'b1, 1'b0);
        step();
        check_slot(0, GF, 1'b1);
        check_slot(1, GE, 1'b1);
        check_slot(2, GE, 1'b1);
        check_slot(3, GB, 1'b1);

        load_vec(16'h12A5, 4'b0101, 4'b0100, 1'b0);
        repeat (15) step();
        check_slot(0, G5, 1'b0);
        check_slot(1, GA, 1'b1);
        check_slot(2, GX, 1'b0);
        check_slot(3, G1, 1'b1);

        step();
        step();
        chk_out("pre_rst", 4'b1110, G5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 4'b1111, GX, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
